mdu_sequencer: RTL and testbench

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_sequencer.sv | 151 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide sequencer for the EX stage: 32-cycle shift-add
// multiply and restoring divide, with HI/LO result registers and stall control.
module mdu_sequencer #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flushE,
  input  logic        mf_req,
  input  logic        mf_sel,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t          state, state_d;
  logic            done_d, dbz_d;
  logic [CW-1:0]   cnt;
  logic [31:0]     acc_hi, acc_lo, opb;
  logic            is_div, dbz_q, neg_res, neg_rem;
  logic            accept, signed_op, b_zero;
  logic [31:0]     abs_a, abs_b;
  logic [32:0]     mul_sum, div_shift, div_diff;
  logic [63:0]     prod, prod_fix;
  logic [31:0]     quo_fix, rem_fix;

  assign accept    = (state == IDLE) && start && !flushE;
  assign signed_op = op[0];
  assign b_zero    = (b == '0);
  assign abs_a     = (signed_op && a[31]) ? -a : a;
  assign abs_b     = (signed_op && b[31]) ? -b : b;

  assign busy    = (state != IDLE);
  assign stall   = busy && (start || mf_req);
  assign mf_data = mf_sel ? hi : lo;

  // Multiply keeps the running product in {acc_hi, acc_lo} with the multiplier
  // consumed from the low end; divide shifts the dividend out of acc_lo into acc_hi.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : 33'd0);
  assign div_shift = {acc_hi, acc_lo[31]};
  assign div_diff  = div_shift - {1'b0, opb};

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_res ? -prod : prod;
  assign quo_fix  = neg_res ? -acc_lo : acc_lo;
  assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op[1] && b_zero) state_d = FIN;
          else if (op[1])      state_d = DIV;
          else                 state_d = MUL;
        end
      end
      MUL, DIV: begin
        if (cnt == CW'(ITER - 1)) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        dbz_d   = dbz_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_d;
      done        <= done_d;
      div_by_zero <= dbz_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            is_div  <= op[1];
            dbz_q   <= op[1] && b_zero;
            neg_res <= signed_op && (a[31] ^ b[31]);
            neg_rem <= signed_op && op[1] && a[31];
            opb     <= abs_b;
            if (op[1]) begin
              acc_hi <= '0;
              acc_lo <= abs_a;
            end else begin
              acc_hi <= '0;
              acc_lo <= abs_b;
              opb    <= abs_a;
            end
          end
        end
        MUL: begin
          cnt    <= cnt + 1'b1;
          acc_hi <= mul_sum[32:1];
          acc_lo <= {mul_sum[0], acc_lo[31:1]};
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          if (!div_diff[32]) begin
            acc_hi <= div_diff[31:0];
            acc_lo <= {acc_lo[30:0], 1'b1};
          end else begin
            acc_hi <= div_shift[31:0];
            acc_lo <= {acc_lo[30:0], 1'b0};
          end
        end
        FIN: begin
          if (!dbz_q) begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed corner cases plus random
// operations compared against a plain-arithmetic model of HI/LO.
module tb_mdu_sequencer;

  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        rst, start, flushE, mf_req, mf_sel;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, stall, done, div_by_zero;
  logic [31:0] hi, lo, mf_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_sequencer #(.ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flushE(flushE), .mf_req(mf_req), .mf_sel(mf_sel),
    .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo), .mf_data(mf_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] ph, input logic [31:0] pl,
                                   output logic [31:0] h, output logic [31:0] l, output logic dz);
    logic [63:0] p;
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    dz = 1'b0;
    h  = ph;
    l  = pl;
    case (o)
      2'd0: begin p = {32'b0, x} * {32'b0, y}; h = p[63:32]; l = p[31:0]; end
      2'd1: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
      2'd2: begin
        if (y == 0) dz = 1'b1;
        else begin l = x / y; h = x % y; end
      end
      default: begin
        if (y == 0) dz = 1'b1;
        else begin q = sx / sy; r = sx % sy; l = q[31:0]; h = r[31:0]; end
      end
    endcase
  endfunction

  // Called in an IDLE cycle; returns in the done cycle so a following call
  // issues back-to-back with done. inject>0 raises a second start in that cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int inject);
    logic [31:0] eh, el;
    logic dz, req;
    int lat;
    ref_calc(o, x, y, m_hi, m_lo, eh, el, dz);
    lat = dz ? 2 : LAT;
    op = o; a = x; b = y; start = 1'b1; flushE = 1'b0; mf_req = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      start = (c == inject);
      if (c == inject) begin op = 2'b10; a = 32'd100; b = 32'd7; end
      req = (c == inject) ? 1'b1 : 1'($urandom_range(0, 1));
      mf_req = req;
      mf_sel = 1'($urandom_range(0, 1));
      #1;
      if (c < lat) begin
        check("busy", busy, 1);
        check("stall", stall, start | req);
        check("done_early", done, 0);
        check("hold_hi", hi, m_hi);
        check("hold_lo", lo, m_lo);
      end else begin
        check("done", done, 1);
        check("busy_end", busy, 0);
        check("stall_end", stall, 0);
        check("dbz", div_by_zero, dz);
        check("hi", hi, eh);
        check("lo", lo, el);
        check("mf_data", mf_data, mf_sel ? eh : el);
      end
    end
    start = 1'b0;
    mf_req = 1'b0;
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b1; flushE = 1'b0; mf_req = 1'b1; mf_sel = 1'b0;
    op = 2'b00; a = 32'd3; b = 32'd4;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst = 1'b0; start = 1'b0; mf_req = 1'b0;
    @(posedge clk); #1;

    run_op(2'd0, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(2'd1, 32'hFFFF_FFFD, 32'd5, 0);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'd2, 32'd5, 32'd0, 0);
    run_op(2'd3, 32'd7, 32'd0, 0);
    run_op(2'd0, $urandom, $urandom, 5);
    run_op(2'd2, 32'd100, 32'd7, 0);

    // issue suppressed by flush
    start = 1'b1; flushE = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; flushE = 1'b0;
    #1;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    check("flush_busy2", busy, 0);
    check("flush_hi", hi, m_hi);
    check("flush_lo", lo, m_lo);

    // reset mid-operation
    op = 2'd1; a = 32'h1234_5678; b = 32'hFEDC_BA98; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1; mf_req = 1'b1;
    @(posedge clk); #1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_stall", stall, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    rst = 1'b0; mf_req = 1'b0;
    m_hi = '0; m_lo = '0;
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    for (int i = 0; i < 25; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 0);
    end

    @(posedge clk); #1;
    check("final_done", done, 0);
    check("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
